// File: rtl/mna_pkg.sv
// Shared constants, flit field layout and sender FSM states for the MNA
// request-path output stage.
package mna_pkg;

  localparam int FLIT_W = 37;
  localparam int NUM_VC = 8;
  localparam int VC_W   = $clog2(NUM_VC);

  localparam logic [1:0] FLIT_HEAD = 2'b10;
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b01;

  localparam int TYPE_HI = 36;
  localparam int TYPE_LO = 35;
  localparam int VC_HI   = 34;
  localparam int VC_LO   = 32;
  localparam int DST_HI  = 31;
  localparam int DST_LO  = 28;
  localparam int SRC_HI  = 27;
  localparam int SRC_LO  = 24;
  localparam int RW_BIT  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2,
    TAIL = 2'd3
  } send_state_t;

endpackage

// File: rtl/mna_flit_sender_if.sv
// Packet-capture and router-injection signals of the flit sender.
// master = upstream/router side, slave = the sender itself.
interface mna_flit_sender_if;
  import mna_pkg::*;

  logic              pkt_valid;
  logic              pkt_ready;
  logic              pkt_write;
  logic [FLIT_W-1:0] header_in;
  logic [FLIT_W-1:0] body_in;
  logic [FLIT_W-1:0] tail_in;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_valid;
  logic [NUM_VC-1:0] credit_in;
  logic [NUM_VC-1:0] vc_has_credit;

  modport master (
    output pkt_valid, pkt_write, header_in, body_in, tail_in, credit_in,
    input  pkt_ready, flit_out, flit_valid, vc_has_credit
  );

  modport slave (
    input  pkt_valid, pkt_write, header_in, body_in, tail_in, credit_in,
    output pkt_ready, flit_out, flit_valid, vc_has_credit
  );

endinterface

// File: rtl/mna_vc_credit_counter.sv
// Saturating up/down credit counter for one virtual channel; resets full.
module mna_vc_credit_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  // simultaneous inc/dec cancel; overflow from a misbehaving router is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= W'(MAX);
    end else if (inc && !dec) begin
      if (count != W'(MAX)) count <= count + 1'b1;
    end else if (dec && !inc) begin
      if (count != '0) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mna_flit_sender.sv
// Captures one request packet and serialises it onto the router injection
// port, one flit per cycle, gated by the per-VC credit of the header's VC.
//
// state | meaning
// IDLE  | ready for a new packet
// HEAD  | head flit pending on vc_q
// BODY  | body flit pending (write packets only)
// TAIL  | tail flit pending; packet done once it is sent
module mna_flit_sender
  import mna_pkg::*;
#(
  parameter int CREDIT_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  mna_flit_sender_if.slave bus
);

  localparam int CNT_W = $clog2(CREDIT_MAX + 1);

  send_state_t       state, state_nxt;
  logic [FLIT_W-1:0] head_q, body_q, tail_q;
  logic              write_q;
  logic [VC_W-1:0]   vc_q;
  logic [CNT_W-1:0]  credit_cnt [NUM_VC];
  logic [NUM_VC-1:0] dec_vc;
  logic              capture;
  logic              credit_ok;
  logic              send;

  assign bus.pkt_ready = (state == IDLE) && !rst;
  assign capture       = bus.pkt_valid && bus.pkt_ready;
  assign credit_ok     = credit_cnt[vc_q] != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      body_q  <= '0;
      tail_q  <= '0;
      write_q <= 1'b0;
      vc_q    <= '0;
    end else if (capture) begin
      head_q  <= bus.header_in;
      body_q  <= bus.body_in;
      tail_q  <= bus.tail_in;
      write_q <= bus.pkt_write;
      vc_q    <= bus.header_in[VC_HI:VC_LO];
    end
  end

  // a flit leaves only when its VC holds credit; otherwise the state holds
  always_comb begin
    state_nxt      = state;
    send           = 1'b0;
    bus.flit_out   = '0;
    bus.flit_valid = 1'b0;
    case (state)
      IDLE: if (capture) state_nxt = HEAD;
      HEAD: if (credit_ok) begin
        send         = 1'b1;
        bus.flit_out = head_q;
        state_nxt    = write_q ? BODY : TAIL;
      end
      BODY: if (credit_ok) begin
        send         = 1'b1;
        bus.flit_out = body_q;
        state_nxt    = TAIL;
      end
      TAIL: if (credit_ok) begin
        send         = 1'b1;
        bus.flit_out = tail_q;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    bus.flit_valid = send;
  end

  assign dec_vc = send ? (NUM_VC'(1) << vc_q) : '0;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_credit
    mna_vc_credit_counter #(.MAX(CREDIT_MAX), .W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bus.credit_in[i]),
      .dec   (dec_vc[i]),
      .count (credit_cnt[i])
    );
  end

  always_comb begin
    bus.vc_has_credit = '0;
    for (int i = 0; i < NUM_VC; i++) bus.vc_has_credit[i] = credit_cnt[i] != '0;
  end

endmodule

// File: tb/tb_mna_flit_sender.sv
// Scoreboard bench for mna_flit_sender: directed scenarios then random packets
// with random credit returns, checked against a per-VC credit/flit-queue model.
`timescale 1ns/1ps
module tb_mna_flit_sender;
  import mna_pkg::*;

  localparam int CMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mna_flit_sender_if bus();

  mna_flit_sender #(.CREDIT_MAX(CMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [FLIT_W-1:0] flit;
    int                vc;
  } exp_t;

  exp_t              exp_q[$];
  int                credits[NUM_VC];
  int                checks = 0;
  int                errors = 0;
  logic [NUM_VC-1:0] credit_dir = '0;
  logic [NUM_VC-1:0] credit_rnd = '0;
  bit                rand_credit_en = 1'b0;

  assign bus.credit_in = credit_dir | credit_rnd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic [1:0] t, input int vc,
                                                  input logic [31:0] p);
    return {t, 3'(vc), p};
  endfunction

  // Presents a packet and holds it until captured in IDLE; with reroll the
  // inputs change every cycle while not ready, so the captured flits are the
  // ones present at the capture edge. Returns at the negedge after capture.
  task automatic send_pkt(input logic w, input logic [FLIT_W-1:0] h, b, t, input bit reroll);
    int                budget;
    logic              ww;
    logic [FLIT_W-1:0] hh, bb, tt;
    budget = 300;
    ww = w; hh = h; bb = b; tt = t;
    @(negedge clk);
    forever begin
      bus.pkt_write = ww;
      bus.header_in = hh;
      bus.body_in   = bb;
      bus.tail_in   = tt;
      bus.pkt_valid = 1'b1;
      if (bus.pkt_ready) break;
      if (budget == 0) begin
        chk("capture_timeout", 64'd0, 64'd1);
        bus.pkt_valid = 1'b0;
        return;
      end
      budget--;
      @(negedge clk);
      if (reroll) begin
        ww = 1'($urandom_range(0, 1));
        hh = mk_flit(FLIT_HEAD, int'($urandom_range(0, NUM_VC - 1)), $urandom());
        bb = mk_flit(FLIT_BODY, int'($urandom_range(0, 7)), $urandom());
        tt = mk_flit(FLIT_TAIL, int'($urandom_range(0, 7)), $urandom());
      end
    end
    exp_q.push_back('{flit: hh, vc: int'(hh[VC_HI:VC_LO])});
    if (ww) exp_q.push_back('{flit: bb, vc: int'(hh[VC_HI:VC_LO])});
    exp_q.push_back('{flit: tt, vc: int'(hh[VC_HI:VC_LO])});
    @(negedge clk);
    bus.pkt_valid = 1'b0;
  endtask

  // Monitor: at posedge+1 first account the edge just taken (send seen in the
  // previous cycle, credit_in as sampled at that edge), then check this cycle.
  initial begin
    bit                last_sent;
    int                last_vc;
    logic [NUM_VC-1:0] exp_has;
    bit                exp_valid;
    exp_t              e;
    last_sent = 1'b0;
    last_vc   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        for (int v = 0; v < NUM_VC; v++) credits[v] = CMAX;
        last_sent = 1'b0;
        chk("rst_flit_valid", 64'(bus.flit_valid), 64'd0);
        chk("rst_has_credit", 64'(bus.vc_has_credit), 64'hff);
      end else begin
        for (int v = 0; v < NUM_VC; v++) begin
          bit inc, dec;
          inc = bus.credit_in[v];
          dec = last_sent && (last_vc == v);
          if (inc && !dec && credits[v] < CMAX) credits[v]++;
          else if (dec && !inc) credits[v]--;
        end
        for (int v = 0; v < NUM_VC; v++) exp_has[v] = credits[v] != 0;
        chk("vc_has_credit", 64'(bus.vc_has_credit), 64'(exp_has));
        exp_valid = (exp_q.size() > 0) && (credits[exp_q[0].vc] != 0);
        chk("flit_valid", 64'(bus.flit_valid), 64'(exp_valid));
        last_sent = 1'b0;
        if (bus.flit_valid && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("flit_out", 64'(bus.flit_out), 64'(e.flit));
          last_sent = 1'b1;
          last_vc   = e.vc;
        end else if (!bus.flit_valid) begin
          chk("flit_out_idle", 64'(bus.flit_out), 64'd0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      credit_rnd = rand_credit_en ? (NUM_VC'($urandom()) & NUM_VC'($urandom())) : '0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FLIT_W-1:0] h, b, t;
    int cnt;
    bus.pkt_valid = 1'b0;
    bus.pkt_write = 1'b0;
    bus.header_in = '0;
    bus.body_in   = '0;
    bus.tail_in   = '0;

    #1 rst = 1'b1;
    #1;
    chk("reset_flit_valid", 64'(bus.flit_valid), 64'd0);
    chk("reset_flit_out", 64'(bus.flit_out), 64'd0);
    chk("reset_pkt_ready", 64'(bus.pkt_ready), 64'd0);
    chk("reset_has_credit", 64'(bus.vc_has_credit), 64'hff);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_reset", 64'(bus.pkt_ready), 64'd1);

    // write packet on VC 3: head/body/tail in k+1..k+3, ready again at k+4
    h = mk_flit(FLIT_HEAD, 3, 32'h1000_0000);
    b = mk_flit(FLIT_BODY, 6, 32'hDEAD_BEEF);
    t = mk_flit(FLIT_TAIL, 1, 32'h0000_1234);
    send_pkt(1'b1, h, b, t, 1'b0);
    chk("wr_head_valid", 64'(bus.flit_valid), 64'd1);
    chk("wr_head", 64'(bus.flit_out), 64'(h));
    @(negedge clk);
    chk("wr_body_valid", 64'(bus.flit_valid), 64'd1);
    chk("wr_body", 64'(bus.flit_out), 64'(b));
    @(negedge clk);
    chk("wr_tail_valid", 64'(bus.flit_valid), 64'd1);
    chk("wr_tail", 64'(bus.flit_out), 64'(t));
    @(negedge clk);
    chk("wr_ready_k4", 64'(bus.pkt_ready), 64'd1);
    chk("wr_idle_valid", 64'(bus.flit_valid), 64'd0);

    // read packet on VC 0: head then tail, tail carries the address
    h = mk_flit(FLIT_HEAD, 0, 32'h2100_0040);
    b = mk_flit(FLIT_BODY, 0, 32'hFFFF_FFFF);
    t = mk_flit(FLIT_TAIL, 0, 32'h8000_0040);
    send_pkt(1'b0, h, b, t, 1'b0);
    chk("rd_head", 64'(bus.flit_out), 64'(h));
    @(negedge clk);
    chk("rd_tail", 64'(bus.flit_out), 64'(t));
    @(negedge clk);
    chk("rd_ready_k3", 64'(bus.pkt_ready), 64'd1);
    chk("rd_no_body", 64'(bus.flit_valid), 64'd0);

    // credit exhaustion on VC 5: 6 flits vs 4 credits
    send_pkt(1'b1, mk_flit(FLIT_HEAD, 5, 32'h5000_0001), mk_flit(FLIT_BODY, 5, 32'h11),
             mk_flit(FLIT_TAIL, 5, 32'h22), 1'b0);
    send_pkt(1'b1, mk_flit(FLIT_HEAD, 5, 32'h5000_0002), mk_flit(FLIT_BODY, 5, 32'h33),
             mk_flit(FLIT_TAIL, 5, 32'h44), 1'b0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.flit_valid) cnt++;
    end
    chk("vc5_stall_count", 64'(cnt), 64'd0);
    chk("vc5_no_credit", 64'(bus.vc_has_credit[5]), 64'd0);
    for (int p = 0; p < 2; p++) begin
      credit_dir[5] = 1'b1;
      @(negedge clk);
      credit_dir[5] = 1'b0;
      cnt = 0;
      for (int c = 0; c < 4; c++) begin
        if (bus.flit_valid) cnt++;
        @(negedge clk);
      end
      chk("vc5_one_per_pulse", 64'(cnt), 64'd1);
    end

    // credit return coinciding with a send on VC 2, then saturation at 4
    send_pkt(1'b0, mk_flit(FLIT_HEAD, 2, 32'h2200_0000), mk_flit(FLIT_BODY, 2, 32'h0),
             mk_flit(FLIT_TAIL, 2, 32'h2200_0010), 1'b0);
    credit_dir[2] = 1'b1;
    @(negedge clk);
    credit_dir[2] = 1'b1;
    @(negedge clk);
    credit_dir[2] = 1'b1;
    @(negedge clk);
    credit_dir[2] = 1'b0;
    chk("vc2_sat_has_credit", 64'(bus.vc_has_credit[2]), 64'd1);
    send_pkt(1'b1, mk_flit(FLIT_HEAD, 2, 32'h2300_0000), mk_flit(FLIT_BODY, 2, 32'h5),
             mk_flit(FLIT_TAIL, 2, 32'h6), 1'b0);
    send_pkt(1'b0, mk_flit(FLIT_HEAD, 2, 32'h2400_0000), mk_flit(FLIT_BODY, 2, 32'h7),
             mk_flit(FLIT_TAIL, 2, 32'h8), 1'b0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.flit_valid) cnt++;
    end
    chk("vc2_drained_stall", 64'(cnt), 64'd0);
    credit_dir[2] = 1'b1;
    @(negedge clk);
    credit_dir[2] = 1'b0;
    repeat (3) @(negedge clk);

    // reset during the body cycle of a write packet
    send_pkt(1'b1, mk_flit(FLIT_HEAD, 1, 32'h1100_0000), mk_flit(FLIT_BODY, 1, 32'hAA),
             mk_flit(FLIT_TAIL, 1, 32'hBB), 1'b0);
    @(negedge clk);
    chk("rst_mid_body_valid", 64'(bus.flit_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid_drop", 64'(bus.flit_valid), 64'd0);
    chk("rst_mid_flit_out", 64'(bus.flit_out), 64'd0);
    chk("rst_mid_ready", 64'(bus.pkt_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready_after", 64'(bus.pkt_ready), 64'd1);
    chk("rst_mid_credit_full", 64'(bus.vc_has_credit), 64'hff);

    // random packets, random gaps, random credit returns, inputs rerolled while waiting
    rand_credit_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int vc;
      vc = int'($urandom_range(0, NUM_VC - 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_pkt(1'($urandom_range(0, 1)), mk_flit(FLIT_HEAD, vc, $urandom()),
               mk_flit(FLIT_BODY, int'($urandom_range(0, 7)), $urandom()),
               mk_flit(FLIT_TAIL, int'($urandom_range(0, 7)), $urandom()), 1'b1);
    end
    for (int w = 0; w < 500 && exp_q.size() > 0; w++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    rand_credit_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
